// File: rtl/phys_mem_pkg.sv
// rtl/phys_mem_pkg.sv - shared types and constants for the physical memory controller
package phys_mem_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int SRAM_AW_DEFAULT     = 20;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    // Wide enough for the largest legal strobe length (15)
    localparam int WAIT_CNT_W = 4;

    // True when every byte-address bit above the SRAM word range is zero
    function automatic logic addr_in_range(input logic [31:0] addr, input int sram_aw);
        return (addr >> (sram_aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/phys_mem_ctrl_if.sv
// rtl/phys_mem_ctrl_if.sv - dev_mem request/response bus between the MMU and the controller
interface phys_mem_ctrl_if;

    logic [31:0] dev_mem_addr;
    logic [31:0] dev_mem_data_out;
    logic        dev_mem_is_write;
    logic        opt_is_lw;
    logic [31:0] dev_mem_data_in;
    logic        dev_mem_busy;

    // CPU/MMU side
    modport master (
        output dev_mem_addr,
        output dev_mem_data_out,
        output dev_mem_is_write,
        output opt_is_lw,
        input  dev_mem_data_in,
        input  dev_mem_busy
    );

    // Memory controller side
    modport slave (
        input  dev_mem_addr,
        input  dev_mem_data_out,
        input  dev_mem_is_write,
        input  opt_is_lw,
        output dev_mem_data_in,
        output dev_mem_busy
    );

endinterface

// File: rtl/phys_mem_ctrl_fetch_bypass_buf.sv
// rtl/phys_mem_ctrl_fetch_bypass_buf.sv - one-entry instruction fetch buffer (used with PHYS_MEM_FETCH_BYPASS_EN)
module fetch_bypass_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic [29:0] fill_addr,
    input  logic [31:0] fill_data,
    input  logic        inval,
    input  logic [29:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_data
);

    logic        valid_q;
    logic [29:0] addr_q;
    logic [31:0] data_q;

    // Entry update: any accepted write kills the entry, a completed fetch refills it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (inval) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr;
            data_q  <= fill_data;
        end
    end

    // Full 30-bit word compare so out-of-range addresses can never alias an entry
    always_comb begin
        hit      = valid_q && (addr_q == lookup_addr);
        hit_data = data_q;
    end

endmodule

// File: rtl/phys_mem_ctrl.sv
// rtl/phys_mem_ctrl.sv - dev_mem to async SRAM controller; optional fetch buffer via PHYS_MEM_FETCH_BYPASS_EN
module phys_mem_ctrl
    import phys_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    phys_mem_ctrl_if.slave     dev,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_dq_in,
    output logic [31:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic [SRAM_AW-1:0]      addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    is_write_q;
    logic                    in_range_q;
    logic                    busy_q;
    logic                    ce_n_q;
    logic                    oe_n_q;
    logic                    we_n_q;
    logic                    dq_oe_q;

    logic                    req_in_range;
    logic                    bypass_hit;
    logic [31:0]             hit_data;
    logic                    access_last;

    assign req_in_range = addr_in_range(dev.dev_mem_addr, SRAM_AW);
    assign access_last  = (state == ST_ACCESS) && (cnt == WAIT_LAST);

`ifdef PHYS_MEM_FETCH_BYPASS_EN
    logic fetch_q;
    logic buf_hit;
    logic buf_fill;
    logic buf_inval;
    logic unused_bits;

    // Only in-range instruction fetches are worth remembering
    assign buf_fill  = access_last && !is_write_q && in_range_q && fetch_q;
    assign buf_inval = (state == ST_IDLE) && dev.dev_mem_is_write;

    fetch_bypass_buf u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .fill        (buf_fill),
        .fill_addr   (30'(addr_q)),
        .fill_data   (sram_dq_in),
        .inval       (buf_inval),
        .lookup_addr (dev.dev_mem_addr[31:2]),
        .hit         (buf_hit),
        .hit_data    (hit_data)
    );

    assign bypass_hit  = (state == ST_IDLE) && !dev.dev_mem_is_write && !dev.opt_is_lw && buf_hit;
    assign unused_bits = ^dev.dev_mem_addr[1:0];
`else
    logic unused_bits;

    assign bypass_hit  = 1'b0;
    assign hit_data    = 32'h0;
    assign unused_bits = ^{dev.dev_mem_addr[1:0], dev.opt_is_lw};
`endif

    // Access sequencer: every output is a register so SRAM strobes are glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
            in_range_q <= 1'b0;
            busy_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
`ifdef PHYS_MEM_FETCH_BYPASS_EN
            fetch_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // A request is always present here, so IDLE lasts exactly one cycle
                    cnt        <= '0;
                    is_write_q <= dev.dev_mem_is_write;
                    in_range_q <= req_in_range;
`ifdef PHYS_MEM_FETCH_BYPASS_EN
                    fetch_q    <= !dev.opt_is_lw;
`endif
                    if (bypass_hit) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        rdata_q <= hit_data;
                    end else begin
                        state <= ST_ACCESS;
                        // Out-of-range requests still walk through ACCESS, strobes idle
                        if (req_in_range) begin
                            addr_q  <= dev.dev_mem_addr[SRAM_AW+1:2];
                            wdata_q <= dev.dev_mem_data_out;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= dev.dev_mem_is_write;
                            dq_oe_q <= dev.dev_mem_is_write;
                        end
                    end
                end

                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WAIT_LAST) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!is_write_q) begin
                            rdata_q <= in_range_q ? sram_dq_in : 32'h0;
                        end
                    end else if (in_range_q && is_write_q) begin
                        // First ACCESS cycle is address setup; WE follows from the second
                        we_n_q <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b1;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign dev.dev_mem_busy    = busy_q;
    assign dev.dev_mem_data_in = rdata_q;
    assign sram_addr           = addr_q;
    assign sram_dq_out         = wdata_q;
    assign sram_dq_oe          = dq_oe_q;
    assign sram_ce_n           = ce_n_q;
    assign sram_oe_n           = oe_n_q;
    assign sram_we_n           = we_n_q;

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// tb/tb_phys_mem_ctrl.sv - directed self-checking bench for phys_mem_ctrl
module tb_phys_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phys_mem_ctrl_if bus0 ();
    phys_mem_ctrl_if bus1 ();
    phys_mem_ctrl_if bus15 ();

    assign bus1.dev_mem_addr      = bus0.dev_mem_addr;
    assign bus1.dev_mem_data_out  = bus0.dev_mem_data_out;
    assign bus1.dev_mem_is_write  = bus0.dev_mem_is_write;
    assign bus1.opt_is_lw         = bus0.opt_is_lw;
    assign bus15.dev_mem_addr     = bus0.dev_mem_addr;
    assign bus15.dev_mem_data_out = bus0.dev_mem_data_out;
    assign bus15.dev_mem_is_write = bus0.dev_mem_is_write;
    assign bus15.opt_is_lw        = bus0.opt_is_lw;

    logic [19:0] addr0, addr1, addr15;
    logic [31:0] dqi0, dqi1, dqi15, dqo0, dqo1, dqo15;
    logic        oe_en0, oe_en1, oe_en15;
    logic        ce0, ce1, ce15, oe0, oe1, oe15, we0, we1, we15;

    phys_mem_ctrl u_dut0 (
        .clk(clk), .rst(rst), .dev(bus0), .sram_addr(addr0), .sram_dq_in(dqi0),
        .sram_dq_out(dqo0), .sram_dq_oe(oe_en0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0)
    );
    phys_mem_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .dev(bus1), .sram_addr(addr1), .sram_dq_in(dqi1),
        .sram_dq_out(dqo1), .sram_dq_oe(oe_en1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
    );
    phys_mem_ctrl #(.WAIT_CYCLES(15)) u_dut15 (
        .clk(clk), .rst(rst), .dev(bus15), .sram_addr(addr15), .sram_dq_in(dqi15),
        .sram_dq_out(dqo15), .sram_dq_oe(oe_en15), .sram_ce_n(ce15), .sram_oe_n(oe15), .sram_we_n(we15)
    );

    // SRAM model for the default instance: unwritten words read back a fixed pattern
    logic [31:0] mem [0:255];
    bit          written [0:255];

    function automatic logic [31:0] pat(input logic [19:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'h111;
    endfunction

    assign dqi0 = (!ce0 && !oe0) ? (written[addr0[7:0]] ? mem[addr0[7:0]] : pat(addr0)) : 32'hFFFF_FFFF;
    assign dqi1  = 32'h5A5A_5A5A ^ 32'(addr1);
    assign dqi15 = 32'h5A5A_5A5A ^ 32'(addr15);

    always @(posedge clk) begin
        if (!ce0 && !we0 && oe_en0) begin
            mem[addr0[7:0]]     <= dqo0;
            written[addr0[7:0]] <= 1'b1;
        end
    end

    // Observation mux for whichever instance the current access targets
    int          sel = 0;
    logic        m_busy, m_ce, m_oe, m_we, m_dqoe;
    logic [31:0] m_data;
    logic [19:0] m_addr;

    always_comb begin
        case (sel)
            1: begin
                m_busy = bus1.dev_mem_busy;  m_data = bus1.dev_mem_data_in;
                m_ce = ce1;  m_oe = oe1;  m_we = we1;  m_dqoe = oe_en1;  m_addr = addr1;
            end
            2: begin
                m_busy = bus15.dev_mem_busy; m_data = bus15.dev_mem_data_in;
                m_ce = ce15; m_oe = oe15; m_we = we15; m_dqoe = oe_en15; m_addr = addr15;
            end
            default: begin
                m_busy = bus0.dev_mem_busy;  m_data = bus0.dev_mem_data_in;
                m_ce = ce0;  m_oe = oe0;  m_we = we0;  m_dqoe = oe_en0;  m_addr = addr0;
            end
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    logic [31:0] r_data, r_addr;
    int          r_lat, r_we, r_ce, r_oe, r_dqoe;

    // One request issued in IDLE; returns latency (IDLE..DONE inclusive) and strobe cycle counts
    task automatic access(input logic wr, input logic lw, input logic [31:0] a, input logic [31:0] d);
        int n;
        bit done;
        bus0.dev_mem_addr     = a;
        bus0.dev_mem_data_out = d;
        bus0.dev_mem_is_write = wr;
        bus0.opt_is_lw        = lw;
        n = 0; done = 0;
        r_we = 0; r_ce = 0; r_oe = 0; r_dqoe = 0; r_addr = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) r_addr = 32'(m_addr);
            if (!m_we)  r_we++;
            if (!m_ce)  r_ce++;
            if (!m_oe)  r_oe++;
            if (m_dqoe) r_dqoe++;
            if (!m_busy) done = 1;
        end
        if (!done) chk("busy_timeout", 32'(n), 32'd0);
        r_lat  = n + 1;
        r_data = m_data;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        bus0.dev_mem_addr = 0; bus0.dev_mem_data_out = 0;
        bus0.dev_mem_is_write = 0; bus0.opt_is_lw = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus0.dev_mem_busy), 32'd1);
        chk("rst_data",  bus0.dev_mem_data_in, 32'd0);
        chk("rst_ce",    32'(ce0), 32'd1);
        chk("rst_oe",    32'(oe0), 32'd1);
        chk("rst_we",    32'(we0), 32'd1);
        chk("rst_dqoe",  32'(oe_en0), 32'd0);
        chk("rst_addr",  32'(addr0), 32'd0);
        chk("rst_dqout", dqo0, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Write then read back
        access(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("wr_lat",  32'(r_lat), 32'd5);
        chk("wr_addr", r_addr, 32'h40);
        chk("wr_we",   32'(r_we), 32'd2);
        chk("wr_ce",   32'(r_ce), 32'd3);
        chk("wr_oe",   32'(r_oe), 32'd0);
        chk("wr_dqoe", 32'(r_dqoe), 32'd3);
        chk("wr_mem",  mem[8'h40], 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h0000_0100, 32'h0);
        chk("rd_lat",  32'(r_lat), 32'd5);
        chk("rd_data", r_data, 32'hDEAD_BEEF);
        chk("rd_oe",   32'(r_oe), 32'd3);
        chk("rd_we",   32'(r_we), 32'd0);
        access(1'b1, 1'b0, 32'h0000_0104, 32'h55AA_55AA);
        chk("wr_keeps_data", r_data, 32'hDEAD_BEEF);

        // Out-of-range accesses never touch the SRAM
        access(1'b0, 1'b1, 32'h8000_0000, 32'h0);
        chk("oor_rd_lat",  32'(r_lat), 32'd5);
        chk("oor_rd_data", r_data, 32'h0);
        chk("oor_rd_ce",   32'(r_ce), 32'd0);
        access(1'b1, 1'b0, 32'h8000_0100, 32'h1234_5678);
        chk("oor_wr_lat", 32'(r_lat), 32'd5);
        chk("oor_wr_ce",  32'(r_ce), 32'd0);
        access(1'b0, 1'b1, 32'h0000_0100, 32'h0);
        chk("oor_wr_mem", r_data, 32'hDEAD_BEEF);

        // Back-to-back sequential reads
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), 32'h0);
            chk("b2b_lat",  32'(r_lat), 32'd5);
            chk("b2b_data", r_data, pat(20'(i)));
        end

        // Fetch buffer behaviour (full latency when the buffer is compiled out)
        access(1'b0, 1'b0, 32'h0000_0200, 32'h0);
        chk("fetch1_lat",  32'(r_lat), 32'd5);
        chk("fetch1_data", r_data, 32'hC0DE_8880);
        access(1'b0, 1'b0, 32'h0000_0200, 32'h0);
        chk("fetch2_data", r_data, 32'hC0DE_8880);
`ifdef PHYS_MEM_FETCH_BYPASS_EN
        chk("fetch2_lat", 32'(r_lat), 32'd2);
        chk("fetch2_ce",  32'(r_ce), 32'd0);
`else
        chk("fetch2_lat", 32'(r_lat), 32'd5);
        chk("fetch2_ce",  32'(r_ce), 32'd3);
`endif
        access(1'b1, 1'b0, 32'h0000_0204, 32'h0BAD_F00D);
        access(1'b0, 1'b0, 32'h0000_0200, 32'h0);
        chk("fetch_inval_lat",  32'(r_lat), 32'd5);
        chk("fetch_inval_data", r_data, 32'hC0DE_8880);
        access(1'b0, 1'b1, 32'h0000_0200, 32'h0);
        chk("load_lat",  32'(r_lat), 32'd5);
        chk("load_data", r_data, 32'hC0DE_8880);

        // Reset in the middle of a write drops strobes without waiting for a clock
        bus0.dev_mem_addr = 32'h0000_0108; bus0.dev_mem_data_out = 32'h77;
        bus0.dev_mem_is_write = 1'b1; bus0.opt_is_lw = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_we_active", 32'(we0), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ce",   32'(ce0), 32'd1);
        chk("mid_rst_we",   32'(we0), 32'd1);
        chk("mid_rst_oe",   32'(oe0), 32'd1);
        chk("mid_rst_dqoe", 32'(oe_en0), 32'd0);
        chk("mid_rst_busy", 32'(bus0.dev_mem_busy), 32'd1);
        chk("mid_rst_data", bus0.dev_mem_data_in, 32'd0);
        @(negedge clk) rst = 1'b1;

        // WAIT_CYCLES = 1
        sel = 1;
        access(1'b1, 1'b0, 32'h0000_0010, 32'h1);
        chk("w1_wr_lat", 32'(r_lat), 32'd4);
        chk("w1_wr_we",  32'(r_we), 32'd1);
        access(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        chk("w1_rd_lat",  32'(r_lat), 32'd4);
        chk("w1_rd_data", r_data, 32'h5A5A_5A5E);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;

        // WAIT_CYCLES = 15
        sel = 2;
        access(1'b1, 1'b0, 32'h0000_0020, 32'h2);
        chk("w15_wr_lat", 32'(r_lat), 32'd18);
        chk("w15_wr_we",  32'(r_we), 32'd15);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0);
        chk("w15_rd_lat",  32'(r_lat), 32'd18);
        chk("w15_rd_data", r_data, 32'h5A5A_5A52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
